// File: rtl/video_timing_checker.sv
// video_timing_checker: sink-side monitor for an hs/vs/de timing stream.
// Recovers pixel coordinates, measures every line and frame against the
// expected timing, and reports sticky mismatch flags plus a lock status.
module video_timing_checker #(
  parameter int HOR_TOTAL_PIXELS  = 1650,
  parameter int HOR_ACTIVE_PIXELS = 1280,
  parameter int HOR_SYNC_PIXELS   = 40,
  parameter int VER_TOTAL_PIXELS  = 750,
  parameter int VER_ACTIVE_PIXELS = 720,
  parameter int VER_SYNC_PIXELS   = 5,
  parameter int LOCK_FRAMES       = 2,
  parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
  parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk_rgb,
  input  logic               rst,
  input  logic               hs,
  input  logic               vs,
  input  logic               de,
  input  logic               err_clear,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               pixel_valid,
  output logic               frame_start,
  output logic               locked,
  output logic [4:0]         err
);

  // Counter widths leave headroom so saturation never aliases a legal value.
  localparam int HC_W = $clog2(2*HOR_TOTAL_PIXELS+1);
  localparam int VC_W = $clog2(VER_TOTAL_PIXELS+2);
  localparam int G_W  = $clog2(LOCK_FRAMES+1);

  localparam logic [HC_W-1:0]    H_TOT  = HC_W'(HOR_TOTAL_PIXELS);
  localparam logic [HC_W-1:0]    H_ACT  = HC_W'(HOR_ACTIVE_PIXELS);
  localparam logic [HC_W-1:0]    H_SYNC = HC_W'(HOR_SYNC_PIXELS);
  localparam logic [HC_W-1:0]    H_WDOG = HC_W'(2*HOR_TOTAL_PIXELS);
  localparam logic [VC_W-1:0]    V_TOT  = VC_W'(VER_TOTAL_PIXELS);
  localparam logic [VC_W-1:0]    V_ACT  = VC_W'(VER_ACTIVE_PIXELS);
  localparam logic [VC_W-1:0]    V_SYNC = VC_W'(VER_SYNC_PIXELS);
  localparam logic [X_WIDTH-1:0] X_MAX  = X_WIDTH'(HOR_ACTIVE_PIXELS-1);
  localparam logic [Y_WIDTH-1:0] Y_MAX  = Y_WIDTH'(VER_ACTIVE_PIXELS-1);
  localparam logic [G_W-1:0]     G_LOCK = G_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [G_W-1:0]    r_good, w_good_nxt;
  logic              r_dirty, w_dirty_nxt;

  logic              r_hs1, r_hs2, r_vs1, r_vs2, r_de1, r_de2;
  logic [HC_W-1:0]   r_h_cnt, r_hs_w, r_de_w;
  logic [VC_W-1:0]   r_line, r_act, r_vsw;
  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;
  logic              r_fs;
  logic [4:0]        r_mis, r_err;
  logic              r_vs_rise_d, r_wdog;

  logic              w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall, w_de_rise, w_de_fall;
  logic              w_wdog, w_any, w_chk;
  logic [4:0]        w_mis;

  assign w_hs_rise = r_hs1 & ~r_hs2;
  assign w_hs_fall = ~r_hs1 & r_hs2;
  assign w_vs_rise = r_vs1 & ~r_vs2;
  assign w_vs_fall = ~r_vs1 & r_vs2;
  assign w_de_rise = r_de1 & ~r_de2;
  assign w_de_fall = ~r_de1 & r_de2;
  assign w_wdog    = (r_h_cnt == H_WDOG) & ~w_hs_rise;

  // Input register plus one extra stage for edge detection.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) {r_hs1, r_hs2, r_vs1, r_vs2, r_de1, r_de2} <= '0;
    else begin
      r_hs1 <= hs; r_hs2 <= r_hs1;
      r_vs1 <= vs; r_vs2 <= r_vs1;
      r_de1 <= de; r_de2 <= r_de1;
    end
  end

  // Horizontal counters: line length (held once the watchdog trips), hs and de run widths.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0; r_hs_w <= '0; r_de_w <= '0;
    end else begin
      if (w_hs_rise)    r_h_cnt <= '0;
      else if (!w_wdog) r_h_cnt <= r_h_cnt + HC_W'(1);
      if (w_hs_rise)                  r_hs_w <= HC_W'(1);
      else if (r_hs1 && r_hs_w != '1) r_hs_w <= r_hs_w + HC_W'(1);
      if (w_de_rise)                  r_de_w <= HC_W'(1);
      else if (r_de1 && r_de_w != '1) r_de_w <= r_de_w + HC_W'(1);
    end
  end

  // Vertical counters: lines per frame, active lines, lines started during vsync.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) begin
      r_line <= '0; r_act <= '0; r_vsw <= '0;
    end else if (w_vs_rise) begin
      r_line <= VC_W'(w_hs_rise);
      r_act  <= VC_W'(w_de_fall);
      r_vsw  <= VC_W'(w_hs_rise);
    end else begin
      if (w_hs_rise && r_line != '1)          r_line <= r_line + VC_W'(1);
      if (w_de_fall && r_act != '1)           r_act  <= r_act + VC_W'(1);
      if (w_hs_rise && r_vs1 && r_vsw != '1)  r_vsw  <= r_vsw + VC_W'(1);
    end
  end

  // Mismatches are judged on the edge that closes each measured interval.
  assign w_mis[0] = (w_hs_rise & ((r_h_cnt + HC_W'(1)) != H_TOT)) | w_wdog;
  assign w_mis[1] = w_hs_fall & (r_hs_w != H_SYNC);
  assign w_mis[2] = w_de_fall & (r_de_w != H_ACT);
  assign w_mis[3] = w_vs_rise & ((r_line != V_TOT) | (r_act != V_ACT));
  assign w_mis[4] = w_vs_fall & (r_vsw != V_SYNC);

  // Coordinates and frame pulse, aligned with the twice-delayed de.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) begin
      r_x <= '0; r_y <= '0; r_fs <= 1'b0;
    end else begin
      r_fs <= w_vs_rise;
      if (w_de_rise)                 r_x <= '0;
      else if (r_de1 && r_x != X_MAX) r_x <= r_x + X_WIDTH'(1);
      if (w_vs_rise)                     r_y <= '0;
      else if (w_de_fall && r_y != Y_MAX) r_y <= r_y + Y_WIDTH'(1);
    end
  end

  // One stage of delay between edge detection and the status state.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) begin
      r_mis <= '0; r_vs_rise_d <= 1'b0; r_wdog <= 1'b0;
    end else begin
      r_mis <= w_mis; r_vs_rise_d <= w_vs_rise; r_wdog <= w_wdog;
    end
  end

  assign w_any = |r_mis;
  assign w_chk = (r_state != SEARCH);

  // Lock state register with the clean-frame counter and dirty-frame mark.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst) begin
      r_state <= SEARCH; r_good <= '0; r_dirty <= 1'b0;
    end else begin
      r_state <= w_state_nxt; r_good <= w_good_nxt; r_dirty <= w_dirty_nxt;
    end
  end

  // Next state: SEARCH ignores mismatches until a frame boundary, CHECK counts clean frames.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_dirty_nxt = r_dirty;
    case (r_state)
      SEARCH: if (r_vs_rise_d) begin
        w_state_nxt = CHECK; w_good_nxt = '0; w_dirty_nxt = 1'b0;
      end
      CHECK: begin
        if (r_wdog) begin
          w_state_nxt = SEARCH; w_good_nxt = '0;
        end else if (r_vs_rise_d) begin
          w_dirty_nxt = 1'b0;
          if (r_dirty || w_any) w_good_nxt = '0;
          else if ((r_good + G_W'(1)) == G_LOCK) begin
            w_good_nxt = G_LOCK; w_state_nxt = LOCKED;
          end else w_good_nxt = r_good + G_W'(1);
        end else if (w_any) w_dirty_nxt = 1'b1;
      end
      LOCKED: begin
        if (r_wdog) begin
          w_state_nxt = SEARCH; w_good_nxt = '0;
        end else if (w_any) begin
          w_state_nxt = CHECK; w_good_nxt = '0; w_dirty_nxt = ~r_vs_rise_d;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // Sticky flags; a clear still lets a same-cycle new mismatch through.
  always_ff @(posedge clk_rgb or posedge rst) begin
    if (rst)            r_err <= '0;
    else if (err_clear) r_err <= w_chk ? r_mis : '0;
    else if (w_chk)     r_err <= r_err | r_mis;
  end

  assign x           = r_x;
  assign y           = r_y;
  assign pixel_valid = r_de2;
  assign frame_start = r_fs;
  assign locked      = (r_state == LOCKED);
  assign err         = r_err;

endmodule

// File: tb/tb_video_timing_checker.sv
// Directed bench for video_timing_checker with small timing parameters.
module tb_video_timing_checker;
  localparam int XW = 4;
  localparam int YW = 3;

  logic          clk_rgb = 1'b0;
  logic          rst, hs, vs, de, err_clear;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          pixel_valid, frame_start, locked;
  logic [4:0]    err;

  int total = 0;
  int bad   = 0;
  bit prev_de = 1'b0;

  logic [4:0] err_h [0:9][0:63];
  logic       lk_h  [0:9][0:63];
  logic       fs_h  [0:9][0:63];

  video_timing_checker #(
    .HOR_TOTAL_PIXELS(20), .HOR_ACTIVE_PIXELS(12), .HOR_SYNC_PIXELS(2),
    .VER_TOTAL_PIXELS(10), .VER_ACTIVE_PIXELS(6), .VER_SYNC_PIXELS(1),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_rgb(clk_rgb), .rst(rst), .hs(hs), .vs(vs), .de(de), .err_clear(err_clear),
    .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .locked(locked), .err(err)
  );

  always #5 clk_rgb = ~clk_rgb;

  // One line: hs high for hsw steps from step 0, de from step 4 for de_len steps.
  task automatic drive_line(input int l, input int len, input int hsw, input int de_len,
                            input bit vsv, input bit act, input int clr, input bit chk,
                            input int row);
    int npv = 0;
    for (int c = 0; c < len; c++) begin
      hs = (c < hsw);
      vs = vsv;
      de = act && (c >= 4) && (c < 4 + de_len);
      err_clear = (c == clr);
      @(posedge clk_rgb); #1;
      if (c < 64) begin
        err_h[l][c] = err; lk_h[l][c] = locked; fs_h[l][c] = frame_start;
      end
      if (chk) begin
        total++;
        if (pixel_valid !== prev_de) begin
          bad++; $display("FAIL pv_delay line %0d step %0d: got %b want %b", l, c, pixel_valid, prev_de);
        end
        if (pixel_valid === 1'b1) begin
          total++;
          if (x !== XW'(npv)) begin
            bad++; $display("FAIL x line %0d step %0d: got %0d want %0d", l, c, x, npv);
          end
          total++;
          if (y !== YW'(row)) begin
            bad++; $display("FAIL y line %0d step %0d: got %0d want %0d", l, c, y, row);
          end
          npv++;
        end
      end
      prev_de = de;
    end
    err_clear = 1'b0;
    if (chk && act) begin
      total++;
      if (npv != de_len) begin
        bad++; $display("FAIL pv_run line %0d: got %0d want %0d", l, npv, de_len);
      end
    end
  endtask

  // Ten-line frame; vs high on line 0, active lines 2..7; optional faults per line.
  task automatic drive_frame(input int long_l, input int short_l, input int hsw_l,
                             input int wd_l, input int clr_l, input int clr_s, input bit chk);
    for (int l = 0; l < 10; l++) begin
      drive_line(l, (l == long_l) ? 21 : (l == wd_l) ? 60 : 20, (l == hsw_l) ? 3 : 2,
                 (l == short_l) ? 11 : 12, (l == 0), (l >= 2 && l < 8),
                 (l == clr_l) ? clr_s : -1, chk, l - 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hs = 0; vs = 0; de = 0; err_clear = 0;
    repeat (3) @(posedge clk_rgb);
    #1;
    total++; if (x !== '0)          begin bad++; $display("FAIL rst_x: got %0d want 0", x); end
    total++; if (y !== '0)          begin bad++; $display("FAIL rst_y: got %0d want 0", y); end
    total++; if (pixel_valid !== 0) begin bad++; $display("FAIL rst_pv: got %b want 0", pixel_valid); end
    total++; if (frame_start !== 0) begin bad++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    total++; if (locked !== 0)      begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (err !== '0)        begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    prev_de = 1'b0;
  endtask

  task automatic test_nominal();
    for (int f = 1; f <= 4; f++) begin
      drive_frame(-1, -1, -1, -1, -1, 0, 1'b1);
      total++; if (fs_h[0][0] !== 1'b0) begin bad++; $display("FAIL fs_early f%0d: got %b want 0", f, fs_h[0][0]); end
      total++; if (fs_h[0][1] !== 1'b1) begin bad++; $display("FAIL fs_pulse f%0d: got %b want 1", f, fs_h[0][1]); end
      total++; if (fs_h[0][2] !== 1'b0) begin bad++; $display("FAIL fs_width f%0d: got %b want 0", f, fs_h[0][2]); end
      total++; if (lk_h[0][1] !== (f >= 4)) begin bad++; $display("FAIL nom_lock1 f%0d: got %b want %b", f, lk_h[0][1], f >= 4); end
      total++; if (lk_h[0][2] !== (f >= 3)) begin bad++; $display("FAIL nom_lock2 f%0d: got %b want %b", f, lk_h[0][2], f >= 3); end
      total++; if (err_h[9][19] !== 5'b0) begin bad++; $display("FAIL nom_err f%0d: got %b want 00000", f, err_h[9][19]); end
    end
  endtask

  task automatic test_long_line();
    drive_frame(5, -1, -1, -1, -1, 0, 1'b1);
    total++; if (lk_h[6][1] !== 1'b1)     begin bad++; $display("FAIL long_lk_before: got %b want 1", lk_h[6][1]); end
    total++; if (err_h[6][1] !== 5'b0)    begin bad++; $display("FAIL long_err_before: got %b want 00000", err_h[6][1]); end
    total++; if (err_h[6][2] !== 5'b00001) begin bad++; $display("FAIL long_err: got %b want 00001", err_h[6][2]); end
    total++; if (lk_h[6][2] !== 1'b0)     begin bad++; $display("FAIL long_unlock: got %b want 0", lk_h[6][2]); end
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b1);
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b1);
    total++; if (lk_h[9][19] !== 1'b0)    begin bad++; $display("FAIL long_early_lock: got %b want 0", lk_h[9][19]); end
    drive_frame(-1, -1, -1, -1, 4, 5, 1'b1);
    total++; if (lk_h[0][1] !== 1'b0)     begin bad++; $display("FAIL relock_early: got %b want 0", lk_h[0][1]); end
    total++; if (lk_h[0][2] !== 1'b1)     begin bad++; $display("FAIL relock: got %b want 1", lk_h[0][2]); end
    total++; if (err_h[0][2] !== 5'b00001) begin bad++; $display("FAIL long_sticky: got %b want 00001", err_h[0][2]); end
    total++; if (err_h[4][4] !== 5'b00001) begin bad++; $display("FAIL clr_before: got %b want 00001", err_h[4][4]); end
    total++; if (err_h[4][5] !== 5'b0)    begin bad++; $display("FAIL clr_after: got %b want 00000", err_h[4][5]); end
    total++; if (lk_h[9][19] !== 1'b1)    begin bad++; $display("FAIL clr_lock: got %b want 1", lk_h[9][19]); end
  endtask

  task automatic test_short_de();
    drive_frame(-1, 3, -1, -1, -1, 0, 1'b1);
    total++; if (err_h[3][16] !== 5'b0)    begin bad++; $display("FAIL short_before: got %b want 00000", err_h[3][16]); end
    total++; if (err_h[3][17] !== 5'b00100) begin bad++; $display("FAIL short_err: got %b want 00100", err_h[3][17]); end
    total++; if (lk_h[3][16] !== 1'b1)     begin bad++; $display("FAIL short_lk_before: got %b want 1", lk_h[3][16]); end
    total++; if (lk_h[3][17] !== 1'b0)     begin bad++; $display("FAIL short_unlock: got %b want 0", lk_h[3][17]); end
    total++; if (err_h[9][19] !== 5'b00100) begin bad++; $display("FAIL short_frame_err: got %b want 00100", err_h[9][19]); end
  endtask

  task automatic test_watchdog();
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
    drive_frame(-1, -1, -1, 9, 1, 5, 1'b0);
    total++; if (lk_h[0][2] !== 1'b1)      begin bad++; $display("FAIL wd_pre_lock: got %b want 1", lk_h[0][2]); end
    total++; if (err_h[9][42] !== 5'b0)    begin bad++; $display("FAIL wd_before: got %b want 00000", err_h[9][42]); end
    total++; if (lk_h[9][42] !== 1'b1)     begin bad++; $display("FAIL wd_lk_before: got %b want 1", lk_h[9][42]); end
    total++; if (err_h[9][43] !== 5'b00001) begin bad++; $display("FAIL wd_err: got %b want 00001", err_h[9][43]); end
    total++; if (lk_h[9][43] !== 1'b0)     begin bad++; $display("FAIL wd_unlock: got %b want 0", lk_h[9][43]); end
    total++; if (lk_h[9][59] !== 1'b0)     begin bad++; $display("FAIL wd_stay: got %b want 0", lk_h[9][59]); end
  endtask

  task automatic test_simultaneous();
    drive_frame(-1, -1, 3, -1, 3, 5, 1'b0);
    total++; if (err_h[3][4] !== 5'b00001) begin bad++; $display("FAIL sim_before: got %b want 00001", err_h[3][4]); end
    total++; if (err_h[3][5] !== 5'b00010) begin bad++; $display("FAIL sim_err: got %b want 00010", err_h[3][5]); end
    total++; if (err_h[9][19] !== 5'b00010) begin bad++; $display("FAIL sim_frame: got %b want 00010", err_h[9][19]); end
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int l = 0; l < 5; l++) drive_line(l, 20, 2, 12, (l == 0), (l >= 2), -1, 1'b0, l - 2);
    drive_line(5, 8, 2, 12, 1'b0, 1'b1, -1, 1'b0, 3);
    total++; if (locked !== 1'b1)     begin bad++; $display("FAIL mid_lock: got %b want 1", locked); end
    total++; if (err !== 5'b00010)    begin bad++; $display("FAIL mid_err: got %b want 00010", err); end
    total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL mid_pv: got %b want 1", pixel_valid); end
    total++; if (x !== 4'd2)          begin bad++; $display("FAIL mid_x: got %0d want 2", x); end
    total++; if (y !== 3'd3)          begin bad++; $display("FAIL mid_y: got %0d want 3", y); end
    rst = 1'b1;
    #1;
    total++; if (x !== '0)          begin bad++; $display("FAIL arst_x: got %0d want 0", x); end
    total++; if (y !== '0)          begin bad++; $display("FAIL arst_y: got %0d want 0", y); end
    total++; if (pixel_valid !== 0) begin bad++; $display("FAIL arst_pv: got %b want 0", pixel_valid); end
    total++; if (frame_start !== 0) begin bad++; $display("FAIL arst_fs: got %b want 0", frame_start); end
    total++; if (locked !== 0)      begin bad++; $display("FAIL arst_locked: got %b want 0", locked); end
    total++; if (err !== '0)        begin bad++; $display("FAIL arst_err: got %b want 0", err); end
    @(posedge clk_rgb); #1;
    rst = 1'b0;
    for (int l = 6; l < 10; l++) drive_line(l, 20, 2, 12, 1'b0, (l < 8), -1, 1'b0, l - 2);
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
    total++; if (err_h[9][19] !== 5'b0) begin bad++; $display("FAIL post_rst_err1: got %b want 00000", err_h[9][19]); end
    total++; if (lk_h[9][19] !== 1'b0)  begin bad++; $display("FAIL post_rst_lock1: got %b want 0", lk_h[9][19]); end
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
    total++; if (lk_h[9][19] !== 1'b0)  begin bad++; $display("FAIL post_rst_lock2: got %b want 0", lk_h[9][19]); end
    drive_frame(-1, -1, -1, -1, -1, 0, 1'b0);
    total++; if (lk_h[0][1] !== 1'b0)   begin bad++; $display("FAIL post_rst_early: got %b want 0", lk_h[0][1]); end
    total++; if (lk_h[0][2] !== 1'b1)   begin bad++; $display("FAIL post_rst_lock3: got %b want 1", lk_h[0][2]); end
    total++; if (err_h[9][19] !== 5'b0) begin bad++; $display("FAIL post_rst_err3: got %b want 00000", err_h[9][19]); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_long_line();
    test_short_de();
    test_watchdog();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_timing_checker.md
# video_timing_checker

Sink-side counterpart of the pixel iterator: consumes an `hs`/`vs`/`de` video timing stream on the pixel clock, recovers pixel coordinates, and measures every line and frame against the expected timing parameters. Reports sticky per-field mismatch flags and a `locked` status once the stream has matched for consecutive whole frames. It sits on the `clk_rgb` domain next to the DVI transmitter, used as an on-chip monitor and as the coordinate source for downstream checkers.

## Interface
- `HOR_TOTAL_PIXELS`, 1650, clocks per line (`hs` rising edge to next `hs` rising edge)
- `HOR_ACTIVE_PIXELS`, 1280, `de` high run length per active line
- `HOR_SYNC_PIXELS`, 40, `hs` high width in clocks
- `VER_TOTAL_PIXELS`, 750, lines per frame (`vs` rising edge to next `vs` rising edge)
- `VER_ACTIVE_PIXELS`, 720, lines containing `de` per frame
- `VER_SYNC_PIXELS`, 5, lines started (`hs` rising edges) while `vs` high
- `LOCK_FRAMES`, 2, consecutive clean frames required for lock (≥1)
- Derived: `X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)`, `Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)`

Ports:
- `clk_rgb`  in  1  pixel clock; the only clock
- `rst`  in  1  asynchronous, active-high reset
- `hs`, `vs`, `de`  in  1 each  timing stream; sync pulses active-high
- `err_clear`  in  1  synchronous single-cycle clear of `err`
- `x`  out  X_WIDTH  column of the current pixel
- `y`  out  Y_WIDTH  row of the current pixel
- `pixel_valid`  out  1  `x`/`y` refer to an active pixel
- `frame_start`  out  1  one-cycle pulse on each detected `vs` rising edge
- `locked`  out  1  stream matched the parameters for `LOCK_FRAMES` frames
- `err`  out  5  sticky mismatch flags: [0] line length or watchdog, [1] hsync width, [2] `de` width, [3] frame lines or active lines, [4] vsync width

## Operation
- Register the inputs once. Detect edges by comparing stage 1 with stage 2.
- `h_cnt` clears on an `hs` rising edge and otherwise increments. At the next rising edge, `h_cnt+1` ≠ `HOR_TOTAL_PIXELS` is a line-length mismatch.
- The `hs` high run is compared to `HOR_SYNC_PIXELS` on the falling edge.
- The `de` run is compared to `HOR_ACTIVE_PIXELS` on the `de` falling edge.
- Line counter:
  - increments on each `hs` rising edge and clears on a `vs` rising edge;
  - at the `vs` rising edge, the completed count ≠ `VER_TOTAL_PIXELS`, or the active-line count (`de` falling edges) ≠ `VER_ACTIVE_PIXELS`, flags err[3].
- Vsync width (`hs` rising edges while `vs` high) is compared to `VER_SYNC_PIXELS` on the `vs` falling edge.
- Coordinates:
  - `x` clears on a `de` rising edge and increments while `de` is high;
  - `y` clears on a `vs` rising edge and increments on each `de` falling edge;
  - both saturate at ACTIVE−1.
- Watchdog: if `h_cnt` reaches `2*HOR_TOTAL_PIXELS`, flag err[0], force SEARCH and hold `h_cnt` until the next `hs` rising edge.
- State machine:
  - SEARCH: mismatches are ignored and `err` is not updated. The first `vs` rising edge moves to CHECK with `good=0`.
  - CHECK: each mismatch sets its `err` bit and marks the frame dirty. On a `vs` rising edge, a clean frame increments `good` and a dirty frame clears it. Reaching `good == LOCK_FRAMES` moves to LOCKED.
  - LOCKED: any mismatch moves to CHECK with `good=0`.
- `locked` = (state == LOCKED).
- `err_clear` and a new mismatch in the same cycle: the new bit is set and the other bits clear.

## Timing
- Reset values: `x=0`, `y=0`, `pixel_valid=0`, `frame_start=0`, `locked=0`, `err=0`, state SEARCH, all counters 0.
- `pixel_valid` equals `de` delayed by 2 clocks. `x`/`y` are aligned with it: the first pixel of a line shows `x=0` 2 clocks after `de` rises at the input.
- `frame_start` pulses 2 clocks after the `vs` rising edge at the input.
- `err` bits and `locked` changes appear 3 clocks after the input edge that triggers them.
- `rst` asserted mid-frame returns every output to its reset value immediately. After release, the block resumes in SEARCH and ignores the partial frame.

## Test plan
Use small parameters to keep runs short: H 20/12/2, V 10/6/1, `LOCK_FRAMES=2`.

- **Nominal:** drive 4 correct frames → `err=0`. `locked` rises 3 clocks after the 3rd `vs` rising edge. Each line gives `pixel_valid` for 12 clocks with `x` 0..11. `y` runs 0..5.
- **Long line:** one line of 21 clocks while locked → err[0]=1 and `locked=0`. Relocks after 2 further clean frames; err[0] stays 1 until `err_clear`.
- **Short `de`:** one `de` run of 11 → err[2]=1. `x` reaches 10 on that line.
- **Watchdog:** stop `hs` for 40 clocks → err[0]=1, state SEARCH, `locked=0`.
- **Simultaneous:** `err_clear` in the same cycle as a new hsync-width mismatch → `err` = 5'b00010.
- **Reset mid-frame:** pulse `rst` at line 5 → outputs return to reset values immediately. No `err` bit is set for the partial frame. `locked` rises after 2 full clean frames following the first `vs` rising edge.
